// File: rtl/cp0_timer_pkg.sv
// cp0_timer_pkg: shared constants and types for the CP0 countdown timer.
//   - register offsets (selected by addr[3:2])
//   - CTRL bit positions and MODE encodings
//   - FSM state enum
//   - HWInt bit index the timer irq is wired to at the CP0 level
package cp0_timer_pkg;

    localparam logic [1:0] REG_CTRL     = 2'd0;
    localparam logic [1:0] REG_PRESET   = 2'd1;
    localparam logic [1:0] REG_COUNT    = 2'd2;
    localparam logic [1:0] REG_PRESCALE = 2'd3;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_MODE_LO = 1;
    localparam int CTRL_MODE_HI = 2;
    localparam int CTRL_IM      = 3;
    localparam int CTRL_W       = 4;

    localparam logic [1:0] MODE_ONESHOT = 2'b00;
    localparam logic [1:0] MODE_RELOAD  = 2'b01;

    localparam int PRESCALE_W = 16;

    // Bit of CP0 HWInt[5:0] driven by this timer's irq.
    localparam int HWINT_BIT = 0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        CNT  = 2'd2,
        INT  = 2'd3
    } state_e;

endpackage

// File: rtl/cp0_timer_prescaler.sv
// cp0_timer_prescaler: 16-bit divider that paces the timer countdown.
// Only instantiated when CP0_TIMER_PRESCALE_EN is defined.
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   load     in   timer is in LOAD: divider restarts from 0
//   run      in   timer is in CNT: divider advances
//   prescale in   divide value; tick when the divider equals it
//   tick     out  countdown step permitted this cycle
module cp0_timer_prescaler
    import cp0_timer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] div_q, div_d;

    assign tick = (div_q == prescale);

    always_comb begin
        div_d = div_q;
        if (load) begin
            div_d = '0;
        end else if (run) begin
            // Restart on every tick so the next step is another prescale+1 cycles away.
            div_d = tick ? '0 : div_q + PRESCALE_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

endmodule

// File: rtl/cp0_timer.sv
// cp0_timer: memory-mapped programmable countdown timer feeding CP0 HWInt.
// Optional build macro: CP0_TIMER_PRESCALE_EN (adds PRESCALE register at
// offset 3 and a divider that slows the countdown).
//   clk    in   system clock, rising edge
//   reset  in   asynchronous active-low reset
//   addr   in   byte offset; addr[3:2] selects CTRL/PRESET/COUNT/PRESCALE
//   we     in   write strobe
//   din    in   write data
//   dout   out  read data, combinational from addr
//   irq    out  IM & flag, to CP0 HWInt
module cp0_timer
    import cp0_timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq
);

    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [CNT_W-1:0]  preset_q, preset_d;
    logic [CNT_W-1:0]  count_q, count_d;
    state_e            state_q, state_d;
    logic              flag_q, flag_d;

    logic [1:0] reg_sel;
    logic       ctrl_wr;
    logic       preset_wr;
    logic       tick;
    logic       unused_addr_bits;

    assign reg_sel          = addr[3:2];
    assign ctrl_wr          = we && (reg_sel == REG_CTRL);
    assign preset_wr        = we && (reg_sel == REG_PRESET);
    assign unused_addr_bits = ^addr[1:0];

`ifdef CP0_TIMER_PRESCALE_EN
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;

    always_comb begin
        prescale_d = prescale_q;
        if (we && (reg_sel == REG_PRESCALE)) begin
            prescale_d = din[PRESCALE_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end

    cp0_timer_prescaler u_prescaler (
        .clk      (clk),
        .reset    (reset),
        .load     (state_q == LOAD),
        .run      (state_q == CNT),
        .prescale (prescale_q),
        .tick     (tick)
    );
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        ctrl_d   = ctrl_q;
        preset_d = preset_q;
        count_d  = count_q;
        state_d  = state_q;
        flag_d   = flag_q;

        case (state_q)
            IDLE: begin
                if (ctrl_q[CTRL_EN]) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!ctrl_q[CTRL_EN]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (count_q == '0) begin
                        state_d = INT;
                        flag_d  = 1'b1;
                    end else begin
                        count_d = count_q - CNT_W'(1);
                    end
                end
            end
            INT: begin
                if (ctrl_q[CTRL_MODE_HI:CTRL_MODE_LO] == MODE_RELOAD) begin
                    flag_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    // One-shot (and reserved modes): stop and leave flag for software.
                    ctrl_d[CTRL_EN] = 1'b0;
                    state_d         = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A CTRL write overrides the FSM's own CTRL/flag updates; clearing EN
        // also drops the FSM to IDLE immediately.
        if (ctrl_wr) begin
            ctrl_d = din[CTRL_W-1:0];
            flag_d = 1'b0;
            if (!din[CTRL_EN]) begin
                state_d = IDLE;
            end
        end

        // New PRESET is only consumed at the next LOAD.
        if (preset_wr) begin
            preset_d = din[CNT_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= '0;
            preset_q <= '0;
            count_q  <= '0;
            state_q  <= IDLE;
            flag_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            preset_q <= preset_d;
            count_q  <= count_d;
            state_q  <= state_d;
            flag_q   <= flag_d;
        end
    end

    always_comb begin
        dout = '0;
        case (reg_sel)
            REG_CTRL:     dout = 32'(ctrl_q);
            REG_PRESET:   dout = 32'(preset_q);
            REG_COUNT:    dout = 32'(count_q);
`ifdef CP0_TIMER_PRESCALE_EN
            REG_PRESCALE: dout = 32'(prescale_q);
`else
            REG_PRESCALE: dout = '0;
`endif
            default:      dout = '0;
        endcase
    end

    assign irq = ctrl_q[CTRL_IM] & flag_q;

endmodule

// File: tb/tb_cp0_timer.sv
module tb_cp0_timer;
    import cp0_timer_pkg::*;

    localparam logic [3:0] A_CTRL   = 4'h0;
    localparam logic [3:0] A_PRESET = 4'h4;
    localparam logic [3:0] A_COUNT  = 4'h8;
    localparam logic [3:0] A_PS     = 4'hC;

    logic        clk   = 1'b0;
    logic        reset = 1'b0;
    logic        we    = 1'b0;
    logic [3:0]  addr  = 4'h0;
    logic [31:0] din   = 32'h0;
    logic [31:0] dout;
    logic        irq;

    int n_pass  = 0;
    int n_total = 0;

    cp0_timer #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .addr  (addr),
        .we    (we),
        .din   (din),
        .dout  (dout),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time budget exceeded, got running expected finished");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] preset;
        logic [3:0]  ctrl;
        int          k;
        logic        exp_irq;
        logic [31:0] exp_count;
        logic [3:0]  exp_ctrl;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input string n, input logic [31:0] p, input logic [3:0] c,
                           input int k, input logic ei, input logic [31:0] ec,
                           input logic [3:0] ectl);
        vec_t v;
        v.name = n; v.preset = p; v.ctrl = c; v.k = k;
        v.exp_irq = ei; v.exp_count = ec; v.exp_ctrl = ectl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // Write is sampled at the next rising edge; returns 1ns after that edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk);
        addr = a;
        din  = d;
        we   = 1'b1;
        @(posedge clk);
        #1;
        we = 1'b0;
    endtask

    task automatic adv(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] d);
        addr = a;
        #1;
        d = dout;
    endtask

    // Start a fresh run: CTRL write at edge t; returns just after edge t.
    task automatic start_run(input logic [31:0] p, input logic [31:0] c);
        wr(A_CTRL, 32'h0);
        wr(A_PRESET, p);
        wr(A_CTRL, c);
    endtask

    initial begin
        logic [31:0] d;

        // ---------------- reset state (reset held low) ----------------
        repeat (2) @(posedge clk);
        #1;
        for (int a = 0; a < 4; a++) begin
            logic [3:0] ad;
            ad = 4'(a * 4);
            rd(ad, d);
            chk($sformatf("reset_reg%0d", a), d, 32'h0);
        end
        chk("reset_irq", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        adv(1);

        // ---------------- reset mid-count ----------------
        wr(A_PRESET, 32'd100);
        wr(A_CTRL, 32'h9);
        adv(18);
        rd(A_COUNT, d);
        chk("midcount_count", d, 32'd84);
        reset = 1'b0;
        #1;
        chk("midrst_irq", 32'(irq), 32'h0);
        rd(A_COUNT, d);  chk("midrst_count", d, 32'h0);
        rd(A_CTRL, d);   chk("midrst_ctrl", d, 32'h0);
        rd(A_PRESET, d); chk("midrst_preset", d, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        adv(5);
        chk("postrst_irq", 32'(irq), 32'h0);
        rd(A_COUNT, d);  chk("postrst_count", d, 32'h0);
        $display("seq reset_midcount done");

        // irq must drop asynchronously, without a clock edge
        wr(A_CTRL, 32'h9);
        adv(3);
        chk("async_irq_before", 32'(irq), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        chk("async_irq_drop", 32'(irq), 32'h0);
        @(negedge clk);
        reset = 1'b1;
        adv(1);
        $display("seq async_irq_drop done");

        // ---------------- table-driven vectors ----------------
        add_vec("os5_k2",  5, 4'h9,  2, 1'b0, 5, 4'h9);
        add_vec("os5_k4",  5, 4'h9,  4, 1'b0, 3, 4'h9);
        add_vec("os5_k7",  5, 4'h9,  7, 1'b0, 0, 4'h9);
        add_vec("os5_k8",  5, 4'h9,  8, 1'b1, 0, 4'h9);
        add_vec("os5_k9",  5, 4'h9,  9, 1'b1, 0, 4'h8);
        add_vec("p0_k2",   0, 4'h9,  2, 1'b0, 0, 4'h9);
        add_vec("p0_k3",   0, 4'h9,  3, 1'b1, 0, 4'h9);
        add_vec("ar3_k6",  3, 4'hB,  6, 1'b1, 0, 4'hB);
        add_vec("ar3_k7",  3, 4'hB,  7, 1'b0, 0, 4'hB);
        add_vec("ar3_k8",  3, 4'hB,  8, 1'b0, 3, 4'hB);
        add_vec("ar3_k17", 3, 4'hB, 17, 1'b0, 0, 4'hB);
        add_vec("ar3_k18", 3, 4'hB, 18, 1'b1, 0, 4'hB);
        add_vec("mask_k5", 2, 4'h1,  5, 1'b0, 0, 4'h1);
        add_vec("mask_k6", 2, 4'h1,  6, 1'b0, 0, 4'h0);
        add_vec("rsv_k10", 7, 4'hD, 10, 1'b1, 0, 4'hD);
        add_vec("rsv_k11", 7, 4'hD, 11, 1'b1, 0, 4'hC);

        for (int i = 0; i < vecs.size(); i++) begin
            logic [31:0] cnt;
            logic [31:0] ctl;
            start_run(vecs[i].preset, 32'(vecs[i].ctrl));
            adv(vecs[i].k);
            chk({vecs[i].name, "_irq"}, 32'(irq), 32'(vecs[i].exp_irq));
            rd(A_COUNT, cnt);
            chk({vecs[i].name, "_count"}, cnt, vecs[i].exp_count);
            rd(A_CTRL, ctl);
            chk({vecs[i].name, "_ctrl"}, ctl, 32'(vecs[i].exp_ctrl));
            $display("vec %0d %s irq=%0b count=%0d ctrl=0x%0h", i, vecs[i].name, irq, cnt, ctl);
        end

        // ---------------- one-shot acknowledge ----------------
        start_run(5, 32'h9);
        adv(9);
        chk("ack_irq_high", 32'(irq), 32'h1);
        wr(A_CTRL, 32'h8);
        chk("ack_irq_cleared", 32'(irq), 32'h0);
        rd(A_CTRL, d);
        chk("ack_ctrl", d, 32'h8);
        $display("seq oneshot_ack done");

        // ---------------- masked flag then CTRL write ----------------
        start_run(2, 32'h1);
        adv(6);
        chk("mask_irq_low", 32'(irq), 32'h0);
        wr(A_CTRL, 32'h8);
        chk("mask_after_im", 32'(irq), 32'h0);
        adv(2);
        chk("mask_stays_low", 32'(irq), 32'h0);
        $display("seq mask done");

        // ---------------- CTRL write colliding with CNT->INT ----------------
        start_run(2, 32'h9);
        adv(4);
        rd(A_COUNT, d);
        chk("coll_count0", d, 32'h0);
        wr(A_CTRL, 32'h9);              // sampled at the CNT->INT edge t+5
        chk("coll_irq_t5", 32'(irq), 32'h0);
        adv(1);
        chk("coll_irq_t6", 32'(irq), 32'h0);
        rd(A_CTRL, d);
        chk("coll_ctrl_t6", d, 32'h8);
        $display("seq collision done");

        // ---------------- PRESET write during CNT ----------------
        start_run(6, 32'hB);
        adv(2);
        rd(A_COUNT, d); chk("pw_count_t2", d, 32'd6);
        wr(A_PRESET, 32'd2);            // sampled at t+3
        rd(A_COUNT, d); chk("pw_count_t3", d, 32'd5);
        adv(1);
        rd(A_COUNT, d); chk("pw_count_t4", d, 32'd4);
        adv(5);
        chk("pw_irq_t9", 32'(irq), 32'h1);
        adv(2);
        rd(A_COUNT, d); chk("pw_count_t11", d, 32'd2);
        chk("pw_irq_t11", 32'(irq), 32'h0);
        adv(2);
        chk("pw_irq_t13", 32'(irq), 32'h0);
        adv(1);
        chk("pw_irq_t14", 32'(irq), 32'h1);
        adv(1);
        wr(A_COUNT, 32'h55);            // read-only: sampled at t+16
        rd(A_COUNT, d); chk("cnt_ro_t16", d, 32'd2);
        adv(1);
        rd(A_COUNT, d); chk("cnt_ro_t17", d, 32'd1);
        $display("seq preset_write done");

`ifndef CP0_TIMER_PRESCALE_EN
        wr(A_PS, 32'hFFFF_FFFF);
        rd(A_PS, d);
        chk("reg3_reads0", d, 32'h0);
`endif

        // ---------------- randomized runs vs arithmetic model ----------------
        for (int trial = 0; trial < 10; trial++) begin
            int          p;
            int          period;
            int          kmax;
            logic [1:0]  mode;
            logic        im;
            logic [3:0]  c;
            logic [31:0] word;
            p      = int'($urandom_range(0, 12));
            mode   = 2'($urandom_range(0, 3));
            im     = 1'($urandom_range(0, 1));
            c      = {im, mode, 1'b1};
            word   = ($urandom() & 32'hFFFF_FFF0) | 32'(c);
            period = p + 3;
            kmax   = 2 + 2 * period + 2;
            start_run(32'(p), word);
            adv(2);
            rd(A_CTRL, d);
            chk($sformatf("rnd%0d_ctrl_rb", trial), d, 32'(c));
            for (int k = 2; k <= kmax; k++) begin
                int          j;
                logic        e_irq;
                logic        e_en;
                logic [31:0] e_cnt;
                j = k - 2;
                if (mode == MODE_RELOAD) begin
                    int ph;
                    ph    = j % period;
                    e_cnt = (ph <= p) ? 32'(p - ph) : 32'h0;
                    e_irq = im && (ph == p + 1);
                    e_en  = 1'b1;
                end else begin
                    e_cnt = (j <= p) ? 32'(p - j) : 32'h0;
                    e_irq = im && (j >= p + 1);
                    e_en  = (j < p + 2);
                end
                chk($sformatf("rnd%0d_k%0d_irq", trial, k), 32'(irq), 32'(e_irq));
                rd(A_COUNT, d);
                chk($sformatf("rnd%0d_k%0d_count", trial, k), d, e_cnt);
                rd(A_CTRL, d);
                chk($sformatf("rnd%0d_k%0d_en", trial, k), 32'(d[0]), 32'(e_en));
                adv(1);
            end
            $display("rnd %0d preset=%0d mode=%0d im=%0b cycles=%0d", trial, p, mode, im, kmax);
        end

`ifdef CP0_TIMER_PRESCALE_EN
        // ---------------- prescaler: PRESCALE=1 halves the count rate ----------------
        wr(A_CTRL, 32'h0);
        wr(A_PS, 32'h1);
        rd(A_PS, d);
        chk("ps_readback", d, 32'h1);
        wr(A_PRESET, 32'd2);
        wr(A_CTRL, 32'h9);
        adv(2);
        rd(A_COUNT, d); chk("ps_count_t2", d, 32'd2);
        adv(1);
        rd(A_COUNT, d); chk("ps_count_t3", d, 32'd2);
        adv(1);
        rd(A_COUNT, d); chk("ps_count_t4", d, 32'd1);
        adv(2);
        rd(A_COUNT, d); chk("ps_count_t6", d, 32'd0);
        adv(1);
        chk("ps_irq_t7", 32'(irq), 32'h0);
        adv(2);
        chk("ps_irq_t9", 32'(irq), 32'h1);
        $display("seq prescale done");
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
